gmii_rx_deframer: RTL and testbench
===================================

GMII_RX_DEFRAMER -- requirements
Module: gmii_rx_deframer

Interface
REQ-001 SHALL have parameter MAX_FRAME_LEN, default 1518, the maximum number of bytes accepted after the SFD, FCS included.
REQ-002 SHALL have port clk  input  1  receive clock; this is the same clock as the PHY-side receive GMII clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port gmii_rxd  input  8  receive data (MII mode: nibble in [3:0]).
REQ-005 SHALL have port gmii_rx_dv  input  1  data valid.
REQ-006 SHALL have port gmii_rx_er  input  1  receive error.
REQ-007 SHALL have port clk_enable  input  1  qualifies each GMII sample; tie high at 1000M.
REQ-008 SHALL have port mii_select  input  1  1 selects nibble (10/100) mode.
REQ-009 SHALL have port m_axis_tdata  output  8  frame byte, with preamble, SFD and FCS removed.
REQ-010 SHALL have port m_axis_tvalid  output  1  byte valid; there is no tready and no backpressure.
REQ-011 SHALL have port m_axis_tlast  output  1  last byte of the frame.
REQ-012 SHALL have port m_axis_tuser  output  1  bad frame, valid only on the tlast beat.
REQ-013 SHALL have port error_bad_frame  output  1  one-cycle pulse: gmii_rx_er seen, oversize frame, or runt frame.
REQ-014 SHALL have port error_bad_fcs  output  1  one-cycle pulse on FCS mismatch.

Function
REQ-015 SHALL register gmii_rxd, gmii_rx_dv and gmii_rx_er once on the clk rising edge; all later logic uses the registered copies, and only cycles with clk_enable=1 count as samples.
REQ-016 SHALL implement a state machine with the states IDLE, PAYLOAD and WAIT_END.
  - IDLE -> PAYLOAD on a sample with dv=1 and byte 0xD5.
  - All other samples in IDLE are ignored, including 0x55 preamble bytes.
REQ-017 SHALL, in PAYLOAD, shift each accepted byte into a 5-entry hold line sr[0..4].
  - If sr[4] is already valid at that moment, sr[4] is emitted with tvalid=1 and tlast=0.
  - Result: byte k appears on the bus 2 clk after byte k+5 is presented at the pins (1000M).
REQ-018 SHALL handle the first sample with dv=0 in PAYLOAD as follows.
  - If sr[4] is valid, emit it with tlast=1; this falls 2 clk after dv falls at the pins.
  - Return to IDLE.
  - The 4 bytes left in sr[0..3] are the FCS and are discarded.
REQ-019 SHALL treat dv falling with sr[4] invalid (fewer than 5 bytes after the SFD) as a runt frame: no beat is emitted, error_bad_frame pulses, and the FSM returns to IDLE.
REQ-020 SHALL compute the CRC over every byte after the SFD, FCS included, using the reflected polynomial 0xEDB88320 with initial value 0xFFFFFFFF.
  - The frame is good iff the register equals 0xDEBB20E3 at the end of the frame.
  - On a mismatch, tuser=1 on the tlast beat and error_bad_fcs pulses in the same cycle.
REQ-021 SHALL latch a sticky error flag if gmii_rx_er=1 with dv=1 on any PAYLOAD sample; the flag forces tuser=1 on tlast and pulses error_bad_frame at tlast.
REQ-022 SHALL handle the sample that takes the accepted count past MAX_FRAME_LEN as follows.
  - Emit sr[4] with tlast=1 and tuser=1.
  - Pulse error_bad_frame.
  - Enter WAIT_END, which drops all samples until dv=0 and then goes to IDLE.
REQ-023 SHALL treat dv=1 with an SFD arriving while in WAIT_END as part of the dropped frame and not start a new frame.
REQ-024 SHALL keep m_axis_tvalid high for exactly one clk per emitted byte; tlast and tuser are 0 whenever tvalid=0.
REQ-025 SHALL size the byte counter to ceil(log2(MAX_FRAME_LEN+2)) bits and saturate it, never wrapping.

Reset
REQ-026 SHALL, while rst=1, immediately force the following to zero: FSM=IDLE, the hold line, the counter, the error flag, CRC=0xFFFFFFFF, and all outputs (tdata=0x00).
REQ-027 SHALL, when rst is asserted mid-frame, emit no tlast beat; after release, the next frame is accepted only after a fresh SFD.

Configuration
REQ-028 SHALL compile nibble assembly in when GMII_RX_MII_EN is defined.
  - With mii_select=1, nibbles pair low-first into bytes.
  - Alignment: IDLE watches {current, previous} nibbles for 0xD5, and pairing starts on the next nibble.
  - dv falling on an odd nibble sets the error flag.
REQ-029 SHALL, when GMII_RX_MII_EN is undefined, ignore mii_select and always treat samples as bytes.

Structure
REQ-030 SHALL place the constants ETH_SFD=0xD5, ETH_PRE=0x55, CRC_POLY=0xEDB88320, CRC_INIT=0xFFFFFFFF and CRC_RESIDUE=0xDEBB20E3, and the FSM state typedef, in the shared package eth_pkg.
REQ-031 SHALL use a single combinational sub-module, crc32_d8: 8-bit data in, 32-bit state in, next state out.

Verification
REQ-032 SHALL cover a good frame: 7x0x55, 0xD5, payload 0x00..0x3B, correct FCS, at 1000M -> 60 beats 0x00..0x3B, tlast on 0x3B, tuser=0, no error pulses.
REQ-033 SHALL cover FCS corruption: the same frame with its last FCS byte XOR 0x01 -> 60 beats, tuser=1 on tlast, a single error_bad_fcs pulse.
REQ-034 SHALL cover gmii_rx_er=1 for one sample on payload byte 10 -> tuser=1 at tlast, a single error_bad_frame pulse.
REQ-035 SHALL cover a runt frame: 0xD5 then 3 bytes, then dv=0 -> no tvalid, a single error_bad_frame pulse.
REQ-036 SHALL cover oversize with MAX_FRAME_LEN=64 and a 100-byte frame -> tlast+tuser after 59 beats, the rest dropped, and the next good frame received intact.
REQ-037 SHALL cover, with GMII_RX_MII_EN defined and mii_select=1 with clk_enable every 10th clk, the frame from REQ-032 sent as nibbles -> output identical to REQ-032.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet receive constants and the deframer state type.
package eth_pkg;

    localparam logic [7:0]  ETH_SFD     = 8'hD5;
    localparam logic [7:0]  ETH_PRE     = 8'h55;
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PAYLOAD  = 2'd1,
        ST_WAIT_END = 2'd2
    } rx_state_t;

endpackage

// File: rtl/crc32_d8.sv
// One-byte step of the reflected Ethernet CRC-32, LSB of the byte first.
module crc32_d8
    import eth_pkg::*;
(
    input  logic [7:0]  data_in,
    input  logic [31:0] crc_in,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data_in[i]) begin
                c = (c >> 1) ^ CRC_POLY;
            end else begin
                c = c >> 1;
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/gmii_rx_deframer.sv
// GMII/MII receive deframer: strips preamble/SFD/FCS, checks CRC and length.
// Optional nibble (10/100) assembly is compiled in with GMII_RX_MII_EN.
module gmii_rx_deframer
    import eth_pkg::*;
#(
    parameter int MAX_FRAME_LEN = 1518
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] gmii_rxd,
    input  logic       gmii_rx_dv,
    input  logic       gmii_rx_er,
    input  logic       clk_enable,
    input  logic       mii_select,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    output logic       m_axis_tlast,
    output logic       m_axis_tuser,
    output logic       error_bad_frame,
    output logic       error_bad_fcs
);

    localparam int CNT_W = $clog2(MAX_FRAME_LEN + 2);

    // Input capture stage
    logic [7:0] rxd_q, rxd_d;
    logic       dv_q, dv_d, er_q, er_d, ce_q, ce_d;

    always_comb begin
        rxd_d = gmii_rxd;
        dv_d  = gmii_rx_dv;
        er_d  = gmii_rx_er;
        ce_d  = clk_enable;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_q <= 8'h00;
            dv_q  <= 1'b0;
            er_q  <= 1'b0;
            ce_q  <= 1'b0;
        end else begin
            rxd_q <= rxd_d;
            dv_q  <= dv_d;
            er_q  <= er_d;
            ce_q  <= ce_d;
        end
    end

    rx_state_t state_q, state_d;

    // Byte-level sample stream seen by the framing FSM
    logic       b_valid;
    logic [7:0] b_data;
    logic       b_er;
    logic       odd_end;

`ifdef GMII_RX_MII_EN
    logic [3:0] prev_nib_q, prev_nib_d, lo_nib_q, lo_nib_d;
    logic       half_q, half_d, er_lo_q, er_lo_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_nib_q <= 4'h0;
            lo_nib_q   <= 4'h0;
            half_q     <= 1'b0;
            er_lo_q    <= 1'b0;
        end else begin
            prev_nib_q <= prev_nib_d;
            lo_nib_q   <= lo_nib_d;
            half_q     <= half_d;
            er_lo_q    <= er_lo_d;
        end
    end

    // Outside PAYLOAD every nibble is offered as {current, previous} so the
    // SFD can be found at either nibble phase; pairing restarts after it.
    always_comb begin
        b_valid    = ce_q;
        b_data     = rxd_q;
        b_er       = er_q;
        odd_end    = 1'b0;
        prev_nib_d = prev_nib_q;
        lo_nib_d   = lo_nib_q;
        half_d     = 1'b0;
        er_lo_d    = 1'b0;
        if (mii_select) begin
            b_valid = 1'b0;
            half_d  = half_q;
            er_lo_d = er_lo_q;
            if (ce_q) begin
                prev_nib_d = rxd_q[3:0];
                if (state_q != ST_PAYLOAD || !dv_q) begin
                    b_valid = 1'b1;
                    b_data  = {rxd_q[3:0], prev_nib_q};
                    odd_end = half_q;
                    half_d  = 1'b0;
                    er_lo_d = 1'b0;
                end else if (!half_q) begin
                    lo_nib_d = rxd_q[3:0];
                    er_lo_d  = er_q;
                    half_d   = 1'b1;
                end else begin
                    b_valid = 1'b1;
                    b_data  = {rxd_q[3:0], lo_nib_q};
                    b_er    = er_q | er_lo_q;
                    half_d  = 1'b0;
                    er_lo_d = 1'b0;
                end
            end
        end
    end
`else
    logic unused_mii_select;
    assign unused_mii_select = mii_select;

    always_comb begin
        b_valid = ce_q;
        b_data  = rxd_q;
        b_er    = er_q;
        odd_end = 1'b0;
    end
`endif

    // Framing state
    logic [4:0][7:0]  sr_q, sr_d;
    logic [4:0]       srv_q, srv_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [31:0]      crc_q, crc_d, crc_next;
    logic [7:0]       tdata_q, tdata_d;
    logic             tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
    logic             bad_frame_q, bad_frame_d, bad_fcs_q, bad_fcs_d;
    logic             eof_bad, fcs_bad;

    crc32_d8 u_crc (
        .data_in (b_data),
        .crc_in  (crc_q),
        .crc_out (crc_next)
    );

    assign eof_bad = err_q | odd_end;
    assign fcs_bad = (crc_q != CRC_RESIDUE);

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        srv_d       = srv_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        crc_d       = crc_q;
        tdata_d     = tdata_q;
        tvalid_d    = 1'b0;
        tlast_d     = 1'b0;
        tuser_d     = 1'b0;
        bad_frame_d = 1'b0;
        bad_fcs_d   = 1'b0;
        if (b_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (dv_q && b_data == ETH_SFD) begin
                        state_d = ST_PAYLOAD;
                        srv_d   = '0;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        crc_d   = CRC_INIT;
                    end
                end
                ST_PAYLOAD: begin
                    if (dv_q) begin
                        if (b_er) begin
                            err_d = 1'b1;
                        end
                        crc_d = crc_next;
                        if (cnt_q != {CNT_W{1'b1}}) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                        tvalid_d = srv_q[4];
                        tdata_d  = srv_q[4] ? sr_q[4] : tdata_q;
                        if (cnt_q == CNT_W'(MAX_FRAME_LEN)) begin
                            // Oversize: close the frame now and drop the rest.
                            tlast_d     = srv_q[4];
                            tuser_d     = srv_q[4];
                            bad_frame_d = 1'b1;
                            state_d     = ST_WAIT_END;
                        end else begin
                            sr_d  = {sr_q[3:0], b_data};
                            srv_d = {srv_q[3:0], 1'b1};
                        end
                    end else begin
                        // End of frame: sr[0..3] hold the FCS and are dropped.
                        if (srv_q[4]) begin
                            tvalid_d    = 1'b1;
                            tdata_d     = sr_q[4];
                            tlast_d     = 1'b1;
                            tuser_d     = eof_bad | fcs_bad;
                            bad_frame_d = eof_bad;
                            bad_fcs_d   = fcs_bad;
                        end else begin
                            bad_frame_d = 1'b1;
                        end
                        err_d   = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
                ST_WAIT_END: begin
                    if (!dv_q) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sr_q        <= '0;
            srv_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            crc_q       <= CRC_INIT;
            tdata_q     <= 8'h00;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tuser_q     <= 1'b0;
            bad_frame_q <= 1'b0;
            bad_fcs_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            srv_q       <= srv_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            crc_q       <= crc_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tuser_q     <= tuser_d;
            bad_frame_q <= bad_frame_d;
            bad_fcs_q   <= bad_fcs_d;
        end
    end

    assign m_axis_tdata    = tdata_q;
    assign m_axis_tvalid   = tvalid_q;
    assign m_axis_tlast    = tlast_q;
    assign m_axis_tuser    = tuser_q;
    assign error_bad_frame = bad_frame_q;
    assign error_bad_fcs   = bad_fcs_q;

endmodule

// File: tb/tb_gmii_rx_deframer.sv
// Directed bench for gmii_rx_deframer (MAX_FRAME_LEN=64); the nibble-mode
// frame is only sent when GMII_RX_MII_EN is defined.
module tb_gmii_rx_deframer;

    typedef logic [7:0] byte_q_t[$];

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] gmii_rxd;
    logic       gmii_rx_dv, gmii_rx_er, clk_enable, mii_select;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid, m_axis_tlast, m_axis_tuser;
    logic       error_bad_frame, error_bad_fcs;

    int n_tests = 0;
    int n_fail  = 0;
    logic mii_mode = 1'b0;

    logic [7:0] cap_data[$];
    logic [1:0] cap_flags[$];
    int n_stray = 0, n_bad_frame = 0, n_bad_fcs = 0;

    always #5 clk = ~clk;

    gmii_rx_deframer #(.MAX_FRAME_LEN(64)) dut (
        .clk             (clk),
        .rst             (rst),
        .gmii_rxd        (gmii_rxd),
        .gmii_rx_dv      (gmii_rx_dv),
        .gmii_rx_er      (gmii_rx_er),
        .clk_enable      (clk_enable),
        .mii_select      (mii_select),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tuser    (m_axis_tuser),
        .error_bad_frame (error_bad_frame),
        .error_bad_fcs   (error_bad_fcs)
    );

    always @(negedge clk) begin
        if (m_axis_tvalid) begin
            cap_data.push_back(m_axis_tdata);
            cap_flags.push_back({m_axis_tlast, m_axis_tuser});
        end else if (m_axis_tlast || m_axis_tuser) begin
            n_stray++;
        end
        if (error_bad_frame) n_bad_frame++;
        if (error_bad_fcs)   n_bad_fcs++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference FCS via the non-reflected MSB-first form, reflected at the end.
    function automatic logic [31:0] eth_fcs(input byte_q_t d);
        logic [31:0] r;
        logic [31:0] rev;
        logic        fb;
        r = 32'hFFFFFFFF;
        foreach (d[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = r[31] ^ d[i][b];
                r  = {r[30:0], 1'b0};
                if (fb) r = r ^ 32'h04C11DB7;
            end
        end
        for (int b = 0; b < 32; b++) rev[b] = r[31 - b];
        return ~rev;
    endfunction

    function automatic byte_q_t make_frame(input int n);
        byte_q_t     q;
        logic [31:0] fcs;
        for (int i = 0; i < n; i++) q.push_back(8'(i));
        fcs = eth_fcs(q);
        for (int i = 0; i < 4; i++) q.push_back(fcs[8*i +: 8]);
        return q;
    endfunction

    task automatic drive(input logic [7:0] d, input logic dv, input logic er);
        int n;
        n = mii_mode ? 10 : 1;
        for (int k = 0; k < n; k++) begin
            gmii_rxd   = d;
            gmii_rx_dv = dv;
            gmii_rx_er = er;
            clk_enable = (k == 0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic put_byte(input logic [7:0] b, input logic dv, input logic er);
        if (mii_mode) begin
            drive({4'h0, b[3:0]}, dv, er);
            drive({4'h0, b[7:4]}, dv, 1'b0);
        end else begin
            drive(b, dv, er);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) put_byte(8'h00, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input byte_q_t d, input int er_idx);
        for (int i = 0; i < 7; i++) put_byte(8'h55, 1'b1, 1'b0);
        put_byte(8'hD5, 1'b1, 1'b0);
        foreach (d[i]) put_byte(d[i], 1'b1, i == er_idx);
        idle(12);
    endtask

    task automatic clear_capture();
        cap_data.delete();
        cap_flags.delete();
        n_stray = 0;
        n_bad_frame = 0;
        n_bad_fcs = 0;
    endtask

    // Expected beats carry 0,1,2,... with tlast/tuser only on the final one.
    task automatic check_frame(input string tag, input int exp_len, input logic exp_tuser,
                               input int exp_bf, input int exp_fcs);
        check({tag, " beats"}, 32'(cap_data.size()), 32'(exp_len));
        for (int i = 0; i < cap_data.size() && i < exp_len; i++) begin
            check($sformatf("%s data%0d", tag, i), 32'(cap_data[i]), 32'(i[7:0]));
            check($sformatf("%s last/user%0d", tag, i), 32'(cap_flags[i]),
                  (i == exp_len - 1) ? 32'({1'b1, exp_tuser}) : 32'd0);
        end
        check({tag, " stray flags"}, 32'(n_stray), 32'd0);
        check({tag, " bad_frame pulses"}, 32'(n_bad_frame), 32'(exp_bf));
        check({tag, " bad_fcs pulses"}, 32'(n_bad_fcs), 32'(exp_fcs));
        $display("[TB] frame %s: %0d beats, bad_frame=%0d bad_fcs=%0d",
                 tag, cap_data.size(), n_bad_frame, n_bad_fcs);
        clear_capture();
    endtask

    initial begin
        byte_q_t f;
        byte_q_t tail;

        rst        = 1'b1;
        gmii_rxd   = 8'hD5;
        gmii_rx_dv = 1'b1;
        gmii_rx_er = 1'b0;
        clk_enable = 1'b1;
        mii_select = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset tvalid", 32'(m_axis_tvalid), 32'd0);
        check("reset tdata", 32'(m_axis_tdata), 32'd0);
        check("reset tlast", 32'(m_axis_tlast), 32'd0);
        check("reset tuser", 32'(m_axis_tuser), 32'd0);
        check("reset bad_frame", 32'(error_bad_frame), 32'd0);
        check("reset bad_fcs", 32'(error_bad_fcs), 32'd0);
        gmii_rx_dv = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(4);
        clear_capture();

        f = make_frame(60);
        send_frame(f, -1);
        check_frame("good", 60, 1'b0, 0, 0);

        f = make_frame(60);
        f[63] = f[63] ^ 8'h01;
        send_frame(f, -1);
        check_frame("bad_fcs", 60, 1'b1, 0, 1);

        f = make_frame(60);
        send_frame(f, 10);
        check_frame("rx_er", 60, 1'b1, 1, 0);

        f = {8'h01, 8'h02, 8'h03};
        send_frame(f, -1);
        check_frame("runt", 0, 1'b0, 1, 0);

        f.delete();
        for (int i = 0; i < 100; i++) f.push_back(8'(i));
        send_frame(f, -1);
        check_frame("oversize", 60, 1'b1, 1, 0);

        f = make_frame(60);
        send_frame(f, -1);
        check_frame("after_oversize", 60, 1'b0, 0, 0);

        // Reset mid-frame: no tlast, and bytes without a fresh SFD are ignored.
        for (int i = 0; i < 7; i++) put_byte(8'h55, 1'b1, 1'b0);
        put_byte(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) put_byte(8'(i), 1'b1, 1'b0);
        rst = 1'b1;
        gmii_rx_dv = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < cap_data.size(); i++)
            check($sformatf("abort data%0d", i), 32'(cap_data[i]), 32'(i[7:0]));
        begin
            int n_last;
            n_last = 0;
            foreach (cap_flags[i]) if (cap_flags[i][1]) n_last++;
            check("abort tlast beats", 32'(n_last), 32'd0);
        end
        clear_capture();
        tail.delete();
        for (int i = 20; i < 40; i++) tail.push_back(8'(i));
        foreach (tail[i]) put_byte(tail[i], 1'b1, 1'b0);
        idle(12);
        check_frame("no_sfd_after_reset", 0, 1'b0, 0, 0);

        f = make_frame(60);
        send_frame(f, -1);
        check_frame("after_reset", 60, 1'b0, 0, 0);

`ifdef GMII_RX_MII_EN
        mii_select = 1'b1;
        mii_mode   = 1'b1;
        idle(4);
        clear_capture();
        f = make_frame(60);
        send_frame(f, -1);
        check_frame("mii_good", 60, 1'b0, 0, 0);
        mii_mode   = 1'b0;
        mii_select = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
